// File: rtl/uart_echo_ctrl.sv
// Purpose : programs the uart config registers after reset, then echoes every RX FIFO word to the TX FIFO.
// Latency : 12 cycles of config after reset; echo is RX pop at k+1, TX push at k+2, back in IDLE at k+4.
// Backpres: a new echo starts only in IDLE with rx_empty=0 and tx_full=0; a started echo always completes.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   echo_en                 allow new echo transactions (config runs regardless)
//   cfg_restart             1-cycle pulse, rerun config once the current echo is done
//   rx_data/rx_empty/rx_read   uart RX FIFO head word, empty flag, pop strobe
//   tx_data/tx_full/tx_write   uart TX FIFO word, full flag, push strobe
//   config_address/config_value/config_store_data   uart config register write port
//   cfg_done, busy, echo_count   status: config complete, not idle, words echoed (wrapping)
module uart_echo_ctrl #(
   parameter int DATA_WIDTH   = 16,
   parameter int CFG_WIDTH    = 24,
   parameter int CFG_DELAY    = 300,
   parameter int CFG_DATABITS = 8,
   parameter int CFG_PARITY   = 1,
   parameter int CFG_STOPBIT  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  echo_en,
   input  logic                  cfg_restart,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_empty,
   output logic                  rx_read,
   input  logic                  tx_full,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_write,
   output logic [2:0]            config_address,
   output logic [CFG_WIDTH-1:0]  config_value,
   output logic                  config_store_data,
   output logic                  cfg_done,
   output logic                  busy,
   output logic [15:0]           echo_count
);

   typedef enum logic [2:0] {
      S_CFG_SET,
      S_CFG_STROBE,
      S_CFG_HOLD,
      S_IDLE,
      S_ECHO_RD,
      S_ECHO_WR,
      S_ECHO_GAP
   } state_t;

   // Register value for each config index, zero-extended to the port width.
   function automatic logic [CFG_WIDTH-1:0] cfg_val(input logic [1:0] idx);
      logic [CFG_WIDTH-1:0] v;
      case (idx)
         2'd0:    v = CFG_WIDTH'(CFG_DELAY);
         2'd1:    v = CFG_WIDTH'(CFG_DATABITS);
         2'd2:    v = CFG_WIDTH'(CFG_PARITY);
         default: v = CFG_WIDTH'(CFG_STOPBIT);
      endcase
      return v;
   endfunction

   state_t                state_q, state_d;
   logic [1:0]            idx_q, idx_d;
   logic                  pending_q, pending_d;
   logic                  rx_read_q, rx_read_d;
   logic                  tx_write_q, tx_write_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic [2:0]            cfg_addr_q, cfg_addr_d;
   logic [CFG_WIDTH-1:0]  cfg_value_q, cfg_value_d;
   logic                  cfg_store_q, cfg_store_d;
   logic                  cfg_done_q, cfg_done_d;
   logic                  busy_q, busy_d;
   logic [15:0]           echo_count_q, echo_count_d;
   logic [1:0]            idx_nxt;

   // All outputs are registered: each is computed from the state being entered,
   // so a strobe is high exactly during the cycle spent in its state.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      pending_d    = pending_q | cfg_restart;
      rx_read_d    = 1'b0;
      tx_write_d   = 1'b0;
      tx_data_d    = tx_data_q;
      cfg_addr_d   = cfg_addr_q;
      cfg_value_d  = cfg_value_q;
      cfg_store_d  = 1'b0;
      cfg_done_d   = cfg_done_q;
      echo_count_d = echo_count_q;
      idx_nxt      = idx_q + 2'd1;

      case (state_q)
         S_CFG_SET: begin
            // Re-driving here covers the cycle straight out of reset, where the
            // outputs are still zero; address/value are then stable during the strobe.
            cfg_addr_d  = {1'b0, idx_q};
            cfg_value_d = cfg_val(idx_q);
            cfg_store_d = 1'b1;
            state_d     = S_CFG_STROBE;
         end
         S_CFG_STROBE: begin
            state_d = S_CFG_HOLD;
         end
         S_CFG_HOLD: begin
            if (idx_q == 2'd3) begin
               cfg_done_d = 1'b1;
               idx_d      = 2'd0;
               state_d    = S_IDLE;
            end else begin
               idx_d       = idx_nxt;
               cfg_addr_d  = {1'b0, idx_nxt};
               cfg_value_d = cfg_val(idx_nxt);
               state_d     = S_CFG_SET;
            end
         end
         S_IDLE: begin
            // A restart wins over an echo that is ready in the same cycle.
            if (pending_q || cfg_restart) begin
               pending_d   = 1'b0;
               cfg_done_d  = 1'b0;
               idx_d       = 2'd0;
               cfg_addr_d  = 3'd0;
               cfg_value_d = cfg_val(2'd0);
               state_d     = S_CFG_SET;
            end else if (echo_en && !rx_empty && !tx_full) begin
               rx_read_d = 1'b1;
               state_d   = S_ECHO_RD;
            end
         end
         S_ECHO_RD: begin
            // The head word is still valid on the edge that completes the pop.
            tx_data_d    = rx_data;
            tx_write_d   = 1'b1;
            echo_count_d = echo_count_q + 16'd1;
            state_d      = S_ECHO_WR;
         end
         S_ECHO_WR: begin
            state_d = S_ECHO_GAP;
         end
         S_ECHO_GAP: begin
            // Dead cycle so the uart FIFO flags reflect the pop/push before IDLE samples them.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_CFG_SET;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_CFG_SET;
         idx_q        <= 2'd0;
         pending_q    <= 1'b0;
         rx_read_q    <= 1'b0;
         tx_write_q   <= 1'b0;
         tx_data_q    <= '0;
         cfg_addr_q   <= 3'd0;
         cfg_value_q  <= '0;
         cfg_store_q  <= 1'b0;
         cfg_done_q   <= 1'b0;
         busy_q       <= 1'b1;
         echo_count_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         rx_read_q    <= rx_read_d;
         tx_write_q   <= tx_write_d;
         tx_data_q    <= tx_data_d;
         cfg_addr_q   <= cfg_addr_d;
         cfg_value_q  <= cfg_value_d;
         cfg_store_q  <= cfg_store_d;
         cfg_done_q   <= cfg_done_d;
         busy_q       <= busy_d;
         echo_count_q <= echo_count_d;
      end
   end

   assign rx_read           = rx_read_q;
   assign tx_write          = tx_write_q;
   assign tx_data           = tx_data_q;
   assign config_address    = cfg_addr_q;
   assign config_value      = cfg_value_q;
   assign config_store_data = cfg_store_q;
   assign cfg_done          = cfg_done_q;
   assign busy              = busy_q;
   assign echo_count        = echo_count_q;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Bench for uart_echo_ctrl: RX/TX FIFO models, word and config scoreboards, random traffic.
module tb_uart_echo_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        echo_en = 1'b0;
   logic        cfg_restart = 1'b0;
   logic [15:0] rx_data = 16'h0;
   logic        rx_empty = 1'b1;
   logic        rx_read;
   logic        tx_full = 1'b0;
   logic [15:0] tx_data;
   logic        tx_write;
   logic [2:0]  config_address;
   logic [23:0] config_value;
   logic        config_store_data;
   logic        cfg_done;
   logic        busy;
   logic [15:0] echo_count;

   uart_echo_ctrl dut (
      .clk(clk), .rst_n(rst_n), .echo_en(echo_en), .cfg_restart(cfg_restart),
      .rx_data(rx_data), .rx_empty(rx_empty), .rx_read(rx_read),
      .tx_full(tx_full), .tx_data(tx_data), .tx_write(tx_write),
      .config_address(config_address), .config_value(config_value),
      .config_store_data(config_store_data), .cfg_done(cfg_done),
      .busy(busy), .echo_count(echo_count)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   logic [15:0] rx_q[$];
   logic [15:0] exp_q[$];
   logic [26:0] cfg_exp_q[$];
   int unsigned cfg_ref[4] = '{300, 8, 1, 0};
   int          cyc = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   logic [15:0] model_cnt = 16'h0;
   int          last_wr_cyc = -100;
   int          wr_gap = 0;
   bit          pop_pending = 1'b0;
   logic        p_rd = 1'b0, p_wr = 1'b0, p_cs = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic upd_rx();
      rx_empty = (rx_q.size() == 0);
      rx_data  = rx_empty ? 16'h0 : rx_q[0];
   endtask

   // An echoed word must come back unchanged and in order.
   task automatic push_word(input logic [15:0] w);
      rx_q.push_back(w);
      exp_q.push_back(w);
      upd_rx();
   endtask

   task automatic push_cfg();
      for (int i = 0; i < 4; i++) cfg_exp_q.push_back({3'(i), 24'(cfg_ref[i])});
   endtask

   // Monitor: strobes observed mid-cycle.
   initial begin
      logic [26:0] ce;
      forever begin
         @(negedge clk);
         cyc++;
         chk("strobe_overlap", {31'b0, rx_read & tx_write}, 32'd0);
         chk("rd_back2back", {31'b0, rx_read & p_rd}, 32'd0);
         chk("wr_back2back", {31'b0, tx_write & p_wr}, 32'd0);
         chk("cfg_back2back", {31'b0, config_store_data & p_cs}, 32'd0);
         if (rx_read) begin
            rd_cnt++;
            chk("rd_underflow", 32'(rx_q.size() == 0), 32'd0);
            pop_pending = 1'b1;
         end
         if (tx_write) begin
            wr_cnt++;
            model_cnt++;
            wr_gap = cyc - last_wr_cyc;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) chk("tx_unexpected", 32'(exp_q.size()), 32'd1);
            else chk("tx_data", {16'h0, tx_data}, {16'h0, exp_q.pop_front()});
            chk("echo_count", {16'h0, echo_count}, {16'h0, model_cnt});
         end
         if (config_store_data) begin
            if (cfg_exp_q.size() == 0) chk("cfg_unexpected", 32'(cfg_exp_q.size()), 32'd1);
            else begin
               ce = cfg_exp_q.pop_front();
               chk("cfg_write", {5'b0, config_address, config_value}, {5'b0, ce});
            end
         end
         p_rd = rx_read;
         p_wr = tx_write;
         p_cs = config_store_data;
      end
   end

   // RX FIFO model completes a pop on the clock edge that ends the strobe cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (pop_pending) begin
            pop_pending = 1'b0;
            if (rst_n && rx_q.size() > 0) rx_q.delete(0);
            upd_rx();
         end
      end
   end

   task automatic do_reset(input bit now);
      int n;
      if (!now) @(negedge clk);
      rst_n = 1'b0;
      rx_q.delete();
      exp_q.delete();
      upd_rx();
      #1;
      chk("rst_rx_read", {31'b0, rx_read}, 32'd0);
      chk("rst_tx_write", {31'b0, tx_write}, 32'd0);
      chk("rst_store", {31'b0, config_store_data}, 32'd0);
      chk("rst_cfg_done", {31'b0, cfg_done}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd1);
      chk("rst_echo_count", {16'h0, echo_count}, 32'd0);
      chk("rst_cfg_bus", {5'b0, config_address, config_value}, 32'd0);
      chk("rst_tx_data", {16'h0, tx_data}, 32'd0);
      model_cnt = 16'h0;
      pop_pending = 1'b0;
      cfg_exp_q.delete();
      push_cfg();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (cfg_done) break;
      end
      chk("cfg_done_latency", n, 32'd12);
      chk("cfg_all_written", 32'(cfg_exp_q.size()), 32'd0);
   endtask

   task automatic drain();
      int n = 0;
      while (n < 3000 && (exp_q.size() != 0 || busy || pop_pending)) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(n < 3000), 32'd1);
   endtask

   task automatic wait_rd();
      int n = 0;
      bit ok = 1'b0;
      while (n < 500) begin
         @(negedge clk);
         n++;
         if (rx_read) begin
            ok = 1'b1;
            break;
         end
      end
      chk("wait_rd_timeout", {31'b0, ok}, 32'd1);
   endtask

   task automatic wait_done(input logic v, input string name);
      int n = 0;
      while (n < 500 && cfg_done !== v) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(n < 500), 32'd1);
   endtask

   initial begin
      int wr0, rd0;
      upd_rx();

      // T1: config after reset, nothing to echo
      do_reset(1'b0);
      repeat (10) @(negedge clk);
      chk("t1_no_rd", rd_cnt, 32'd0);
      chk("t1_no_wr", wr_cnt, 32'd0);
      chk("t1_idle", {31'b0, busy}, 32'd0);

      // echo_en low holds IDLE even with data waiting
      push_word(16'h1234);
      repeat (10) @(negedge clk);
      chk("en_low_hold", rd_cnt, 32'd0);
      echo_en = 1'b1;
      drain();

      // T2: two words at peak rate
      @(negedge clk);
      push_word(16'h0041);
      push_word(16'hBEEF);
      drain();
      chk("t2_gap", wr_gap, 32'd4);
      chk("t2_count", {16'h0, echo_count}, 32'd3);

      // T3: tx_full blocks new transactions
      @(negedge clk);
      tx_full = 1'b1;
      rd0 = rd_cnt;
      for (int i = 0; i < 3; i++) push_word(16'($urandom));
      repeat (20) @(negedge clk);
      chk("t3_no_rd", rd_cnt - rd0, 32'd0);
      chk("t3_rx_held", 32'(rx_q.size()), 32'd3);
      tx_full = 1'b0;
      drain();
      chk("t3_rx_empty", 32'(rx_q.size()), 32'd0);
      chk("t3_count", {16'h0, echo_count}, 32'd6);

      // T4: restart during ECHO_RD
      push_word(16'hA5A5);
      push_word(16'h5A5A);
      wait_rd();
      wr0 = wr_cnt;
      #1 cfg_restart = 1'b1;
      push_cfg();
      @(negedge clk);
      cfg_restart = 1'b0;
      wait_done(1'b0, "t4_cfg_fall_timeout");
      chk("t4_word_done", wr_cnt, 32'(wr0 + 1));
      wait_done(1'b1, "t4_cfg_rise_timeout");
      chk("t4_cfg_rewritten", 32'(cfg_exp_q.size()), 32'd0);
      chk("t4_no_echo_in_cfg", wr_cnt, 32'(wr0 + 1));
      drain();
      chk("t4_second_word", wr_cnt, 32'(wr0 + 2));

      // T5: reset during ECHO_RD
      push_word(16'hC0DE);
      wait_rd();
      wr0 = wr_cnt;
      #1;
      do_reset(1'b1);
      repeat (6) @(negedge clk);
      chk("t5_no_wr", wr_cnt, 32'(wr0));
      chk("t5_count", {16'h0, echo_count}, 32'd0);

      // T6: 1..50 then random words, with tx_full randomly asserted
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         tx_full = ($urandom_range(0, 3) == 0);
         push_word(i <= 50 ? 16'(i) : 16'($urandom));
         repeat ($urandom_range(0, 5)) begin
            @(negedge clk);
            tx_full = ($urandom_range(0, 3) == 0);
         end
      end
      @(negedge clk);
      tx_full = 1'b0;
      drain();
      chk("t6_rx_empty", 32'(rx_q.size()), 32'd0);
      chk("t6_count", {16'h0, echo_count}, 32'd80);

      // echo_count wraps from FFFF to 0
      @(negedge clk);
      force dut.echo_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.echo_count_q;
      model_cnt = 16'hFFFF;
      @(negedge clk);
      chk("wrap_preload", {16'h0, echo_count}, 32'h0000FFFF);
      push_word(16'h7777);
      drain();
      chk("wrap_zero", {16'h0, echo_count}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

endmodule
